ahb_timer_array: RTL and testbench

AHB-Lite slave providing `NUM_CH` independent down-counting timers that share one programmable prescaler. Each channel is one-shot or periodic, has its own interrupt status and enable, and drives a per-channel IRQ. The block sits on the data-side AHB bus behind the address decoder and multiplexor. It is the parametrised, multi-channel successor to the single-channel AHB timer; its OR-ed `timer_irq` feeds the core's `irqs` vector.

---
 rtl/ahb_timer_array_if.sv | 34 +++
 rtl/ahb_timer_array.sv | 203 ++++++++++++++++++++
 tb/tb_ahb_timer_array.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_timer_array_if.sv
// ---------------------------------------------------------------------------
// ahb_timer_array_if
//   AHB-Lite slave-side bus bundle for ahb_timer_array.
//
//   master modport (bus side / testbench):
//     HSEL, HREADY, HADDR[31:0], HTRANS[1:0], HWRITE, HWDATA[31:0] -> out
//     HRDATA[31:0], HREADYOUT                                      <- in
//   slave modport (timer block): the same signals, directions reversed.
//
//   Handshake: an address phase is accepted on a rising clock edge where
//   HSEL & HREADY & HTRANS[1] are all high. The data phase is the following
//   cycle and completes on the next edge at which HREADY is high. The slave
//   never stalls, so HREADYOUT is tied high.
// ---------------------------------------------------------------------------
interface ahb_timer_array_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_timer_array.sv
// ---------------------------------------------------------------------------
// ahb_timer_array
//   NUM_CH independent down-counting timers sharing one prescaler, behind a
//   zero-wait-state AHB-Lite slave port.
//
//   Ports:
//     clock      in   bus clock (HCLK), the only clock of the block
//     reset      in   asynchronous, active-high reset
//     bus        slave modport of ahb_timer_array_if (AHB-Lite signals)
//     irq        out  per-channel interrupt, registered status & irq_en
//     timer_irq  out  OR of all channel interrupts, registered
//
//   Register map (byte offsets, HADDR[8:2] decoded):
//     ch*0x10 + 0x0 LOAD   RW   reload value
//     ch*0x10 + 0x4 VALUE  RO   current count
//     ch*0x10 + 0x8 CTRL   RW   bit0 enable, bit1 periodic, bit2 irq_en
//     ch*0x10 + 0xC STAT   R/W1C bit0 status
//     0x100 IRQ_STATUS     RO   status of all channels
//     0x104 PRESCALE       RW   prescaler reload value
// ---------------------------------------------------------------------------
module ahb_timer_array #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  ahb_timer_array_if.slave    bus,
  output logic [NUM_CH-1:0]   irq,
  output logic                timer_irq
);

  // -------------------------------------------------------------------------
  // Address phase capture
  // -------------------------------------------------------------------------
  logic       act_q;   // a transfer to this slave is in its data phase
  logic       wr_q;
  logic [6:0] addr_q;  // word address HADDR[8:2]
  logic       accept;

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (bus.HREADY) begin
      act_q  <= accept;
      wr_q   <= bus.HWRITE;
      addr_q <= bus.HADDR[8:2];
    end
  end

  logic       wr_en;
  logic       chan_slot;  // address falls in the 0x000-0x0FF channel window
  logic [3:0] ch_idx;
  logic [1:0] reg_sel;
  logic       wr_pre;

  assign wr_en     = act_q & wr_q & bus.HREADY;
  assign chan_slot = ~addr_q[6];
  assign ch_idx    = addr_q[5:2];
  assign reg_sel   = addr_q[1:0];
  assign wr_pre    = wr_en & (addr_q == 7'h41);

  // Address/transfer bits that the register map does not decode.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:9], bus.HADDR[1:0], bus.HTRANS[0]};

  // -------------------------------------------------------------------------
  // Shared prescaler: tick fires on the cycle pcnt is 0, then pcnt reloads.
  // A new PRESCALE value only matters at the next reload.
  // -------------------------------------------------------------------------
  logic [PRE_WIDTH-1:0] prescale_q;
  logic [PRE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                 tick;

  assign tick   = (pcnt_q == '0);
  assign pcnt_d = tick ? prescale_q : (pcnt_q - PRE_WIDTH'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      if (wr_pre) prescale_q <= bus.HWDATA[PRE_WIDTH-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Channels
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0] stat_vec;
  logic [NUM_CH-1:0] ien_vec;
  logic [31:0]       ch_rd [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] load_q;
    logic [CNT_WIDTH-1:0] value_q;
    logic                 en_q, per_q, ien_q, stat_q;
    logic                 hit, wr_load, wr_ctrl, wr_stat, evt, start;

    assign hit     = wr_en & chan_slot & (ch_idx == 4'(i));
    assign wr_load = hit & (reg_sel == 2'd0);
    assign wr_ctrl = hit & (reg_sel == 2'd2);
    assign wr_stat = hit & (reg_sel == 2'd3);
    assign evt     = tick & en_q & (value_q == '0);
    // Only a 0->1 enable transition reloads; re-writing enable=1 does not.
    assign start   = wr_ctrl & ~en_q & bus.HWDATA[0];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        load_q  <= '0;
        value_q <= '0;
        en_q    <= 1'b0;
        per_q   <= 1'b0;
        ien_q   <= 1'b0;
        stat_q  <= 1'b0;
      end else begin
        if (wr_load) load_q <= bus.HWDATA[CNT_WIDTH-1:0];

        if (start) begin
          value_q <= load_q;
        end else if (tick && en_q) begin
          if (value_q != '0) value_q <= value_q - CNT_WIDTH'(1);
          else if (per_q)    value_q <= load_q;
        end

        // A CTRL write overrides the one-shot auto-disable on the same edge.
        if (wr_ctrl) begin
          en_q  <= bus.HWDATA[0];
          per_q <= bus.HWDATA[1];
          ien_q <= bus.HWDATA[2];
        end else if (evt && !per_q) begin
          en_q <= 1'b0;
        end

        // An event on the same edge as a clear keeps status set.
        if (evt)                          stat_q <= 1'b1;
        else if (wr_stat && bus.HWDATA[0]) stat_q <= 1'b0;
      end
    end

    always_comb begin
      ch_rd[i] = '0;
      case (reg_sel)
        2'd0: ch_rd[i] = 32'(load_q);
        2'd1: ch_rd[i] = 32'(value_q);
        2'd2: ch_rd[i] = {29'd0, ien_q, per_q, en_q};
        2'd3: ch_rd[i] = {31'd0, stat_q};
        default: ch_rd[i] = '0;
      endcase
    end

    assign stat_vec[i] = stat_q;
    assign ien_vec[i]  = ien_q;
  end

  // -------------------------------------------------------------------------
  // Interrupt outputs, one register stage after status/irq_en
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0] irq_q;
  logic              timer_irq_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q       <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      irq_q       <= stat_vec & ien_vec;
      timer_irq_q <= |(stat_vec & ien_vec);
    end
  end

  assign irq       = irq_q;
  assign timer_irq = timer_irq_q;

  // -------------------------------------------------------------------------
  // Read data: combinational from the registered address, read phases only
  // -------------------------------------------------------------------------
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = '0;
    if (act_q && !wr_q) begin
      if (chan_slot) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) rdata_d = ch_rd[i];
        end
      end else if (addr_q == 7'h40) begin
        rdata_d = 32'(stat_vec);
      end else if (addr_q == 7'h41) begin
        rdata_d = 32'(prescale_q);
      end
    end
  end

  assign bus.HRDATA    = rdata_d;
  assign bus.HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_timer_array.sv
module tb_ahb_timer_array;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PW  = 16;
  localparam logic [31:0] CMASK = 32'((64'd1 << CW) - 64'd1);
  localparam logic [31:0] PMASK = 32'((64'd1 << PW) - 64'd1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   started = 1'b0;
  always #5 clk = ~clk;

  ahb_timer_array_if bus ();
  logic [NCH-1:0] dut_irq;
  logic           timer_irq;

  ahb_timer_array #(.NUM_CH(NCH), .CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .irq       (dut_irq),
    .timer_irq (timer_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", nm, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Timers are described by a tick schedule (next tick cycle) and per-channel
  // remaining counts; the bus is tracked as "which register is in its data phase".
  logic [31:0] m_load [NCH];
  logic [31:0] m_cnt  [NCH];
  bit          m_en [NCH], m_per [NCH], m_ien [NCH], m_st [NCH];
  logic [31:0] m_pre;
  longint      m_cyc, m_next_tick;
  bit          m_act, m_wr, m_rd_phase;
  logic [8:0]  m_addr;
  logic [NCH-1:0] m_irq;
  bit          m_tirq;
  logic [31:0] exp_q [$];

  task model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_load[i] = 0; m_cnt[i] = 0; m_en[i] = 0; m_per[i] = 0; m_ien[i] = 0; m_st[i] = 0;
    end
    m_pre = 0; m_cyc = 0; m_next_tick = 0;
    m_act = 0; m_wr = 0; m_rd_phase = 0; m_addr = 0;
    m_irq = '0; m_tirq = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(logic [8:0] a);
    int ch;
    logic [31:0] r;
    r = 0;
    ch = int'(a) / 16;
    if (a == 9'h100) begin
      for (int i = 0; i < NCH; i++) r[i] = m_st[i];
    end else if (a == 9'h104) begin
      r = m_pre;
    end else if (a < 9'h100 && ch < NCH) begin
      case (int'(a) % 16)
        0:  r = m_load[ch];
        4:  r = m_cnt[ch];
        8:  r = {29'd0, m_ien[ch], m_per[ch], m_en[ch]};
        12: r = {31'd0, m_st[ch]};
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  bit          tick, wr, evt, o_en, o_per, is_ch;
  logic [31:0] wd, o_load;
  int          ch, off;
  logic [NCH-1:0] irq_new;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      tick = (m_cyc == m_next_tick);
      if (tick) m_next_tick = m_cyc + longint'(m_pre) + 1;
      wr    = m_act && m_wr;
      wd    = bus.HWDATA;
      ch    = int'(m_addr) / 16;
      off   = int'(m_addr) % 16;
      is_ch = wr && (m_addr < 9'h100) && (ch < NCH);
      for (int i = 0; i < NCH; i++) begin
        irq_new[i] = m_st[i] & m_ien[i];
        o_load = m_load[i]; o_en = m_en[i]; o_per = m_per[i];
        evt = 0;
        if (tick && o_en) begin
          if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            evt = 1;
            if (o_per) m_cnt[i] = o_load;
            else       m_en[i]  = 0;
          end
        end
        if (is_ch && ch == i) begin
          case (off)
            0: m_load[i] = wd & CMASK;
            8: begin
              if (!o_en && wd[0]) m_cnt[i] = o_load;
              m_en[i] = wd[0]; m_per[i] = wd[1]; m_ien[i] = wd[2];
            end
            12: if (wd[0]) m_st[i] = 0;
            default: ;
          endcase
        end
        if (evt) m_st[i] = 1;
      end
      if (wr && m_addr == 9'h104) m_pre = wd & PMASK;
      m_irq  = irq_new;
      m_tirq = |irq_new;
      m_cyc++;
      if (bus.HREADY) begin
        m_act  = bus.HSEL && bus.HTRANS[1];
        m_wr   = bus.HWRITE;
        m_addr = bus.HADDR[8:0] & 9'h1FC;
      end
      m_rd_phase = m_act && !m_wr;
      if (m_rd_phase) exp_q.push_back(model_read(m_addr));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_v;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_irq", 32'(dut_irq), 32'd0);
      chk("rst_timer_irq", 32'(timer_irq), 32'd0);
      chk("rst_hrdata", bus.HRDATA, 32'd0);
      chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    end else if (started) begin
      chk("irq", 32'(dut_irq), 32'(m_irq));
      chk("timer_irq", 32'(timer_irq), 32'(m_tirq));
      chk("hreadyout", 32'(bus.HREADYOUT), 32'd1);
      if (m_rd_phase) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL hrdata_noexp at %0t: actual=0x%0h expected=<queued value>", $time, bus.HRDATA);
        end else begin
          exp_v = exp_q.pop_front();
          chk($sformatf("hrdata@%03h", m_addr), bus.HRDATA, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = w; bus.HADDR = a;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr_phase(a, 1'b1);
    @(negedge clk); bus.HWDATA = d; set_idle();
  endtask

  task automatic ahb_read(input logic [31:0] a);
    @(negedge clk); addr_phase(a, 1'b0);
    @(negedge clk); set_idle();
  endtask

  task automatic read_burst(input logic [31:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); addr_phase(a, 1'b0);
    end
    @(negedge clk); set_idle();
  endtask

  // Write followed by a pipelined read of the same register.
  task automatic wr_rd(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr_phase(a, 1'b1);
    @(negedge clk); bus.HWDATA = d; addr_phase(a, 1'b0);
    @(negedge clk); set_idle();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic read_all();
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 4; r++) ahb_read(32'(s * 16 + r * 4));
    ahb_read(32'h100); ahb_read(32'h104); ahb_read(32'h108); ahb_read(32'h1FC);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] hi, base, a;
  int op, c;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    bus.HREADY = 1'b1; bus.HADDR = '0; bus.HWDATA = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    started = 1'b1;

    // Reset values of every register.
    read_all();

    // Periodic ch0, PRESCALE 0, VALUE read every cycle.
    ahb_write(32'h104, 0);
    ahb_write(32'h000, 3);
    ahb_write(32'h008, 7);
    read_burst(32'h004, 10);
    idle_cycles(10);

    // One-shot ch1 with PRESCALE 4, then clear its status.
    ahb_write(32'h008, 0);
    ahb_write(32'h104, 4);
    ahb_write(32'h010, 2);
    ahb_write(32'h018, 5);
    idle_cycles(20);
    ahb_read(32'h018); ahb_read(32'h014);
    wr_rd(32'h01C, 1);
    idle_cycles(3);

    // ch2 event against STAT clear at every phase offset.
    ahb_write(32'h104, 0);
    ahb_write(32'h00C, 1);
    idle_cycles(6);
    ahb_write(32'h020, 3);
    ahb_write(32'h028, 7);
    for (int k = 0; k < 6; k++) begin
      idle_cycles(k);
      ahb_write(32'h02C, 1);
      ahb_read(32'h02C);
    end
    ahb_write(32'h028, 0);
    ahb_write(32'h02C, 1);
    ahb_read(32'h02C);

    // All channels periodic with LOAD = channel index.
    for (int i = 0; i < NCH; i++) ahb_write(32'(i * 16 + 12), 1);
    for (int i = 0; i < NCH; i++) ahb_write(32'(i * 16), 32'(i));
    for (int i = 0; i < NCH; i++) ahb_write(32'(i * 16 + 8), 7);
    read_burst(32'h100, 12);
    ahb_write(32'h0F0, 32'hFFFF_FFFF);
    ahb_read(32'h0F0); ahb_read(32'h0F8);
    ahb_write(32'h104, 32'hABCD_1234);
    ahb_read(32'h104);
    ahb_write(32'h104, 0);

    // Reset in the middle of a count with ch0's interrupt up.
    ahb_write(32'h000, 9);
    ahb_write(32'h008, 0);
    ahb_write(32'h008, 7);
    idle_cycles(14);
    ahb_read(32'h004);
    do_reset();
    read_all();
    idle_cycles(30);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      op   = $urandom_range(0, 9);
      c    = $urandom_range(0, NCH);
      hi   = $urandom() & 32'hFFFF_FE03;
      base = 32'(c * 16) | hi;
      case (op)
        0: ahb_write(base, 32'($urandom_range(0, 7)));
        1, 2: ahb_write(base + 8, $urandom());
        3: ahb_write(base + 12, $urandom());
        4: ahb_write(32'h104 | hi, 32'($urandom_range(0, 3)));
        5: ahb_read(base + 32'(4 * $urandom_range(0, 3)));
        6: begin
          a = ($urandom_range(0, 1) == 1) ? 32'h100 : base + 32'(4 * $urandom_range(0, 3));
          read_burst(a, $urandom_range(1, 4));
        end
        7: wr_rd(base, 32'($urandom_range(0, 7)));
        8: begin
          @(negedge clk);
          bus.HSEL = 1'($urandom_range(0, 1));
          bus.HTRANS = bus.HSEL ? 2'($urandom_range(0, 1)) : 2'b10;
          bus.HWRITE = 1'b1;
          bus.HADDR = 32'($urandom_range(0, 511));
          @(negedge clk); bus.HWDATA = $urandom(); set_idle();
        end
        default: idle_cycles($urandom_range(1, 5));
      endcase
    end

    idle_cycles(3);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
